onehot_state_reg: RTL
=====================

# onehot_state_reg

Parametrised one-hot state register for the design's control state machines. It holds an N-bit one-hot state vector and loads the next state under an enable. It checks every loaded next state for one-hot legality and recovers to the reset state if the vector is illegal. It also reports a sticky error, a state-change pulse, the binary index of the current state and a saturating dwell counter.

## Interface
- N: default 5; number of states, ≥2.
- RST_IDX: default 0; index of the state loaded by reset and by illegal-vector recovery, 0..N-1.
- CNT_W: default 8; dwell counter width, ≥1.
- IDX_W: derived, $clog2(N); not overridable.

- clk  in  1  clock; all flops capture on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  load enable for nxt_state.
- nxt_state  in  N  candidate next state; must be one-hot.
- clr_err  in  1  clears err_sticky.
- state  out  N  registered one-hot state.
- state_idx  out  IDX_W  binary index of the set bit of state; combinational from state.
- changed  out  1  registered one-cycle pulse; state differs from its previous value.
- illegal  out  1  registered one-cycle pulse; the last load attempt was not one-hot.
- err_sticky  out  1  registered; set by any illegal load, held until clr_err.
- dwell  out  CNT_W  registered count of cycles since the last state change; saturates.

## Operation
- Reset (rst=1 at posedge) sets state to one-hot(RST_IDX), with dwell=0, changed=0, illegal=0 and err_sticky=0.
  - rst has priority over en, nxt_state and clr_err.
- en=0:
  - state holds.
  - changed=0 and illegal=0.
  - dwell increments and saturates at 2^CNT_W-1.
- en=1 with nxt_state one-hot (exactly one bit set):
  - state loads nxt_state and illegal=0.
  - If nxt_state≠state: changed=1 and dwell=0.
  - If nxt_state=state: changed=0 and dwell increments (saturating).
- en=1 with nxt_state not one-hot (all zero, or two or more bits set):
  - state loads one-hot(RST_IDX) and illegal=1.
  - err_sticky is set.
  - changed=1 and dwell=0 only if state was not already one-hot(RST_IDX); otherwise changed=0 and dwell increments.
- clr_err=1 clears err_sticky on the next edge.
  - If an illegal load occurs in the same cycle, set wins and err_sticky stays 1.
- The one-hot check applies only when en=1; nxt_state is ignored when en=0.
- state_idx decodes state. Since state is always one-hot by construction, no illegal decode case is reachable.

## Timing
- Latency is one cycle from en/nxt_state to state.
- changed, illegal, err_sticky and dwell are aligned with the new state value, on the same edge.
- state_idx has zero latency relative to state.
- dwell reads 0 in the first cycle of a new state and k in the (k+1)th cycle, up to saturation.
- Back-to-back loads every cycle are supported, with no bubbles.
- changed and illegal are pulses: high for exactly one cycle per qualifying load.
  - They stay high on consecutive cycles only if consecutive loads qualify.

## Structure
- Package onehot_pkg holds:
  - function is_onehot(vec), returning 1 iff popcount==1;
  - function onehot2idx(vec);
  - a localparam helper for IDX_W.
- Sub-module onehot_chk: a combinational legality checker, parametrised by N, output legal. It is instantiated once on nxt_state.
- The dwell counter is inline, with the saturation compare at all-ones.
- No other sub-modules.

## Test plan
All scenarios use N=5, RST_IDX=0, CNT_W=4.
- Reset: rst=1 for one cycle -> state=5'b00001, state_idx=0, dwell=0, err_sticky=0, changed=0, illegal=0.
- Ring rotate: en=1 with nxt_state={state[3:0],state[4]} for 5 cycles -> state=00010, 00100, 01000, 10000, 00001; changed=1 and dwell=0 every cycle; state_idx=1,2,3,4,0.
- Hold/saturate: en=0 for 20 cycles from state 00100 -> state holds 00100; dwell=1..15 then stays 15; changed=0.
- Illegal vector: from 01000, en=1 with nxt_state=5'b00110 -> state=00001, illegal=1 for one cycle, changed=1, err_sticky=1. Then en=1 with nxt_state=5'b00000 -> state=00001, illegal=1, changed=0.
- Sticky clear: clr_err=1 in the same cycle as an illegal load -> err_sticky=1. Next cycle clr_err=1 with a legal load -> err_sticky=0.
- Reset mid-operation: state=01000, dwell=3, err_sticky=1; assert rst together with en=1 and nxt_state=10000 -> state=00001, dwell=0, err_sticky=0, changed=0.

Source files
------------

// File: rtl/onehot_pkg.sv
// Shared helpers for one-hot state vectors: legality test, index decode and
// the index-width rule used by every one-hot register.
package onehot_pkg;

    // Widest vector the helpers accept; narrower vectors are zero-extended.
    localparam int MAX_N = 64;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic is_onehot(input logic [MAX_N-1:0] vec);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_N; i++) begin
            cnt = cnt + int'(vec[i]);
        end
        return (cnt == 1);
    endfunction

    function automatic int onehot2idx(input logic [MAX_N-1:0] vec);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_chk.sv
// Combinational legality checker: legal is high iff exactly one bit of vec is set.
module onehot_chk
    import onehot_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0] vec,
    output logic         legal
);

    assign legal = is_onehot(MAX_N'(vec));

endmodule

// File: rtl/onehot_state_reg.sv
// One-hot state register with illegal-vector recovery, sticky error flag,
// change pulse, binary index decode and a saturating dwell counter.
module onehot_state_reg
    import onehot_pkg::*;
#(
    parameter int N       = 5,
    parameter int RST_IDX = 0,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N-1:0]              nxt_state,
    input  logic                      clr_err,
    output logic [N-1:0]              state,
    output logic [idx_width(N)-1:0]   state_idx,
    output logic                      changed,
    output logic                      illegal,
    output logic                      err_sticky,
    output logic [CNT_W-1:0]          dwell
);

    localparam int               IDX_W     = idx_width(N);
    localparam logic [N-1:0]     RST_STATE = N'(1) << RST_IDX;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic         legal;
    logic [N-1:0] load_p0;
    logic         bad_p0;
    logic         chg_p0;

    onehot_chk #(.N(N)) u_chk (
        .vec   (nxt_state),
        .legal (legal)
    );

    // Stage p0: choose the value to load; an illegal vector falls back to reset state.
    always_comb begin
        load_p0 = state;
        bad_p0  = 1'b0;
        if (en) begin
            if (legal) begin
                load_p0 = nxt_state;
            end else begin
                load_p0 = RST_STATE;
                bad_p0  = 1'b1;
            end
        end
        chg_p0 = (load_p0 != state);
    end

    // Stage p1: register state and all status aligned to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RST_STATE;
            changed    <= 1'b0;
            illegal    <= 1'b0;
            err_sticky <= 1'b0;
            dwell      <= '0;
        end else begin
            state   <= load_p0;
            changed <= chg_p0;
            illegal <= bad_p0;
            dwell   <= chg_p0 ? '0 : sat_inc(dwell);
            // A new illegal load outranks a clear request in the same cycle.
            if (bad_p0) begin
                err_sticky <= 1'b1;
            end else if (clr_err) begin
                err_sticky <= 1'b0;
            end
        end
    end

    assign state_idx = IDX_W'(onehot2idx(MAX_N'(state)));

endmodule
